// File: rtl/bioee_vector_player.sv
// bioee_vector_player
//   Paced playback engine on the read side of the BioEE vector FIFO
//   (vectorclk domain). Pops one 32-bit word at a time and holds it on
//   vectoroutput for clk_div + 2 cycles, holds the last vector on FIFO
//   underflow and counts underflow stall cycles (saturating).
//
// Ports
//   vectorclk        sole clock
//   vectorreset      asynchronous active-high reset (shared with the FIFO)
//   start / stop     single-cycle control pulses (stop wins when both high)
//   clk_div          PLAY-state hold cycles per vector, latched at LOAD
//   fifo_dout        FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty       FIFO empty flag
//   fifo_rd_en       FIFO read enable (FETCH only, never while empty)
//   vectoroutput     registered vector to the device under test
//   vector_strobe    one-cycle pulse with each new vectoroutput value
//   busy             state != IDLE
//   underflow        registered; high while stalled on an empty FIFO
//   underflow_count  saturating count of underflow stall cycles
//
// Build option
//   BIOEE_VPLAYER_IDLE_ZERO_EN : when defined, entering IDLE through stop
//   clears vectoroutput (one cycle late when stop lands in LOAD, so the
//   popped word is still shown). When undefined the last vector is held.
//
// State table
//   state   | meaning
//   IDLE    | not playing, waiting for start
//   FETCH   | request next word; retries every cycle while empty
//   LOAD    | popped word is on fifo_dout; register it and latch clk_div
//   PLAY    | hold current vector for div_lim cycles

module bioee_vector_player #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 vectorclk,
  input  logic                 vectorreset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [31:0]          fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [31:0]          vectoroutput,
  output logic                 vector_strobe,
  output logic                 busy,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 have_vec;
  logic [DIV_WIDTH-1:0] div_lim;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 play_done;
  logic                 go;
  logic                 load_en;
  logic                 stall;
`ifdef BIOEE_VPLAYER_IDLE_ZERO_EN
  logic                 zero_pend;
  logic                 stop_clear;
`endif

  // PLAY is only entered with div_lim >= 1, so div_lim - 1 never wraps there.
  assign play_done = (div_cnt == div_lim - DIV_WIDTH'(1));

  // State register
  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (stop)             state_nxt = S_IDLE;
        else if (!fifo_empty) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // The load itself always completes; stop only redirects the exit.
        if (stop)                 state_nxt = S_IDLE;
        else if (clk_div == '0)   state_nxt = S_FETCH;
        else                      state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (stop)           state_nxt = S_IDLE;
        else if (play_done) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    fifo_rd_en = (state == S_FETCH) && !fifo_empty && !stop;
    busy       = (state != S_IDLE);
    go         = (state == S_IDLE) && start && !stop;
    load_en    = (state == S_LOAD);
    // An empty FIFO before the first vector is a normal start-up wait, not an underflow.
    stall      = (state == S_FETCH) && fifo_empty && have_vec && !stop;
  end

`ifdef BIOEE_VPLAYER_IDLE_ZERO_EN
  assign stop_clear = stop && ((state == S_FETCH) || (state == S_PLAY));
`endif

  // Datapath registers
  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) begin
      vectoroutput    <= '0;
      vector_strobe   <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
      have_vec        <= 1'b0;
      div_lim         <= '0;
      div_cnt         <= '0;
`ifdef BIOEE_VPLAYER_IDLE_ZERO_EN
      zero_pend       <= 1'b0;
`endif
    end else begin
      vector_strobe <= load_en;

      if (load_en) begin
        vectoroutput <= fifo_dout;
        div_lim      <= clk_div;
        div_cnt      <= '0;
      end else if (state == S_PLAY) begin
        div_cnt <= div_cnt + DIV_WIDTH'(1);
      end

`ifdef BIOEE_VPLAYER_IDLE_ZERO_EN
      // zero_pend covers stop-in-LOAD: the word is shown for one cycle first.
      zero_pend <= load_en && stop;
      if (zero_pend || stop_clear) vectoroutput <= '0;
`endif

      if (go)           have_vec <= 1'b0;
      else if (load_en) have_vec <= 1'b1;

      if (go || load_en || stop) underflow <= 1'b0;
      else if (stall)            underflow <= 1'b1;

      if (go)                                        underflow_count <= '0;
      else if (stall && (underflow_count != '1))     underflow_count <= underflow_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/bioee_vector_player.md
# bioee_vector_player

Paced playback engine on the read side of the BioEE vector FIFO (`fifo_w32_1024_r32_1024`) in the `vectorclk` domain. It replaces the free-running `rd_en = 1` with a controlled read. Each 32-bit word is held on `vectoroutput` for a programmable number of cycles. The block supports start and stop, holds the last vector on FIFO underflow, and counts underflow events for host readback.

## Interface
Parameters:
- `DIV_WIDTH`, 16: width of `clk_div`.
- `CNT_WIDTH`, 16: width of `underflow_count`.

Ports:
- `vectorclk`, in, 1: sole clock.
- `vectorreset`, in, 1: asynchronous, active-high reset. The FIFO shares this reset.
- `start`, in, 1: single-cycle pulse that begins playback.
- `stop`, in, 1: single-cycle pulse that ends playback.
- `clk_div`, in, DIV_WIDTH: PLAY-state hold cycles per vector.
- `fifo_dout`, in, 32: FIFO read data. Valid the cycle after `fifo_rd_en` (standard-read FIFO).
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO read enable.
- `vectoroutput`, out, 32: registered vector to the DUT.
- `vector_strobe`, out, 1: one-cycle pulse, high in the first cycle of each new vector.
- `busy`, out, 1: high when state ≠ IDLE.
- `underflow`, out, 1: registered. High while stalled on an empty FIFO after the first vector.
- `underflow_count`, out, CNT_WIDTH: saturating count of underflow stall cycles.

## Operation
The state machine has four states: IDLE, FETCH, LOAD, PLAY.
- **IDLE:**
  - `fifo_rd_en = 0`.
  - If `start && !stop`: go to FETCH, clear `underflow_count`, clear `have_vec`.
  - `start` in any other state is ignored.
- **FETCH:**
  - `fifo_rd_en = !fifo_empty` (combinational, FETCH state only).
  - If not empty: go to LOAD.
  - If empty and `have_vec = 1`: `underflow` = 1, `underflow_count` += 1 (saturating at all-ones). Stay in FETCH and retry every cycle.
  - If empty and `have_vec = 0`: wait silently; no count.
- **LOAD:**
  - `vectoroutput <= fifo_dout`.
  - `vector_strobe <= 1`.
  - `have_vec <= 1`, `underflow <= 0`.
  - Latch `div_lim <= clk_div`, `div_cnt <= 0`.
  - If `clk_div == 0`: go to FETCH. Otherwise: go to PLAY.
- **PLAY:**
  - `div_cnt` increments each cycle.
  - When `div_cnt == div_lim - 1`: go to FETCH.
- **Vector period:** `clk_div + 2` cycles while the FIFO is non-empty.
- **Mid-period changes:** a change to `clk_div` takes effect at the next LOAD.
- **stop:**
  - In FETCH or PLAY: go to IDLE next cycle; `fifo_rd_en` deasserts immediately.
  - In LOAD: the load completes (the popped word is not lost), then go to IDLE.
  - `stop` and `start` in the same cycle: `stop` wins.
- **Underflow:** `vectoroutput` always holds its last value during an underflow stall.
- **In IDLE:** `vectoroutput` holds its value (see Configuration). `underflow_count` holds its value until the next `start`.

## Timing
- **Reset values:** `vectoroutput = 0`, `vector_strobe = 0`, `busy = 0`, `underflow = 0`, `underflow_count = 0`, `fifo_rd_en = 0`, state = IDLE, `have_vec = 0`.
- **Reset mid-operation:** takes effect immediately. The partially read word is discarded.
- **Start latency** (FIFO non-empty):
  - `start` at cycle 0.
  - FETCH at cycle 1 with `fifo_rd_en = 1`.
  - LOAD at cycle 2.
  - `vectoroutput` and `vector_strobe` update at the cycle-3 edge.
- `vector_strobe` and the new `vectoroutput` value appear in the same cycle.
- `fifo_rd_en` is high for exactly one cycle per vector consumed. It is never asserted while `fifo_empty = 1`.

## Configuration
- `BIOEE_VPLAYER_IDLE_ZERO_EN`:
  - Defined: entering IDLE via `stop` clears `vectoroutput` to 0 on the same edge as the state change. If `stop` arrives in LOAD, the loaded word is shown for one cycle before clearing.
  - Undefined: `vectoroutput` holds the last played vector in IDLE.
- Underflow hold behaviour is identical with or without the macro.

## Test plan
- **Reset:**
  - Stimulus: assert `vectorreset` mid-PLAY with output 0xDEADBEEF.
  - Response: all outputs are 0 and state is IDLE while reset is high. No `fifo_rd_en` until the next `start`.
- **Paced playback:**
  - Stimulus: write 0x11111111, 0x22222222, 0x33333333; `clk_div = 2`; `start`.
  - Response: each value is held 4 cycles; 3 `vector_strobe` pulses; 3 `fifo_rd_en` cycles; `underflow_count = 0` before the FIFO drains.
- **Full-rate playback:**
  - Stimulus: `clk_div = 0`, 4 words.
  - Response: a new vector every 2 cycles; `busy` stays high.
- **Underflow:**
  - Stimulus: 1 word, then 10 cycles with the FIFO empty, then write 0xA5A5A5A5.
  - Response: output holds word 1; `underflow = 1`; `underflow_count = 10`; 0xA5A5A5A5 appears 2 cycles after `fifo_empty` falls; `underflow` returns to 0.
- **Stop handling:**
  - Stimulus: `stop` during PLAY; later `start` and `stop` in the same cycle.
  - Response: IDLE next cycle, output held (0 with the macro defined); the simultaneous pulse keeps the block in IDLE with no read.
- **Saturation:**
  - Stimulus: `CNT_WIDTH = 4`, 20 underflow cycles.
  - Response: `underflow_count = 15`; the next `start` clears it to 0.
